// File: rtl/if_stage_pkg.sv
// Shared pipeline constants for the fetch stage and its downstream ID/EX neighbours.
// Also defines the IF/ID register update codes produced by the next-PC selector.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  // Clears the byte offset so the PC stays word-aligned.
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_e;

endpackage

// File: rtl/Add.sv
// 32-bit ripple-carry adder shared across the datapath.
// The carry out of the top bit is dropped, so sums wrap modulo 2^32.
module Add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [31:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign y[i] = a[i] ^ b[i] ^ c[i];
    if (i < 31) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/pc_next_sel.sv
// Next-PC and IF/ID update selection for the fetch stage.
// Priority, highest first: redirect, stall, memory not ready, normal advance.
module pc_next_sel
  import if_stage_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc4,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            redirect,
  input  logic            stall,
  input  logic            flush,
  input  logic            ready,
  output logic [XLEN-1:0] pc_nxt,
  output ifid_op_e        ifid_op
);

  always_comb begin
    pc_nxt  = pc;
    ifid_op = IFID_HOLD;
    if (redirect) begin
      // A redirect kills the wrong-path fetch even while stalled.
      pc_nxt  = redirect_pc & PC_ALIGN_MASK;
      ifid_op = IFID_BUBBLE;
    end else if (stall) begin
      if (flush) ifid_op = IFID_BUBBLE;
    end else if (!ready) begin
      ifid_op = IFID_BUBBLE;
    end else begin
      pc_nxt  = pc4;
      ifid_op = flush ? IFID_BUBBLE : IFID_LOAD;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, PC+4 adder and the IF/ID pipeline register.
// imem_addr_o is the current PC; all ifid_* outputs come straight from flops.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            imem_ready_i,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pc4_o,
  output logic [XLEN-1:0] ifid_instr_o,
  output logic            ifid_valid_o
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] pc_nxt;
  ifid_op_e        ifid_op;

  Add u_pc_add (
    .a (pc),
    .b (32'd4),
    .y (pc4)
  );

  pc_next_sel u_sel (
    .pc          (pc),
    .pc4         (pc4),
    .redirect_pc (redirect_pc_i),
    .redirect    (redirect_i),
    .stall       (stall_i),
    .flush       (flush_i),
    .ready       (imem_ready_i),
    .pc_nxt      (pc_nxt),
    .ifid_op     (ifid_op)
  );

  assign imem_addr_o = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC & PC_ALIGN_MASK;
      ifid_pc_o    <= '0;
      ifid_pc4_o   <= '0;
      ifid_instr_o <= NOP_INSTR;
      ifid_valid_o <= 1'b0;
    end else begin
      pc <= pc_nxt;
      case (ifid_op)
        IFID_LOAD: begin
          ifid_pc_o    <= pc;
          ifid_pc4_o   <= pc4;
          ifid_instr_o <= imem_rdata_i;
          ifid_valid_o <= 1'b1;
        end
        IFID_BUBBLE: begin
          ifid_pc_o    <= '0;
          ifid_pc4_o   <= '0;
          ifid_instr_o <= NOP_INSTR;
          ifid_valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: table of one-cycle vectors plus hand sequences
// for reset-time wrap-around and reset overriding stall/redirect.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect, ready;
  logic [31:0] redirect_pc;
  logic [31:0] addr, rdata, ipc, ipc4, instr;
  logic        valid;
  logic [31:0] addr2, rdata2, ipc2, ipc42, instr2;
  logic        valid2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word at address A reads as 0x1000 + A.
  assign rdata  = 32'h1000 + addr;
  assign rdata2 = 32'h1000 + addr2;

  if_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_addr_o(addr), .imem_rdata_i(rdata), .imem_ready_i(ready),
    .ifid_pc_o(ipc), .ifid_pc4_o(ipc4), .ifid_instr_o(instr), .ifid_valid_o(valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_addr_o(addr2), .imem_rdata_i(rdata2), .imem_ready_i(ready),
    .ifid_pc_o(ipc2), .ifid_pc4_o(ipc42), .ifid_instr_o(instr2), .ifid_valid_o(valid2)
  );

  typedef struct {
    logic        stall, flush, redirect, ready;
    logic [31:0] rpc;
    logic [31:0] addr, ipc, ipc4, instr;
    logic        valid;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic s, logic f, logic r, logic rdy, logic [31:0] rp,
                              logic [31:0] a, logic [31:0] p, logic [31:0] p4,
                              logic [31:0] ins, logic v);
    vec_t t;
    t.stall = s; t.flush = f; t.redirect = r; t.ready = rdy; t.rpc = rp;
    t.addr = a; t.ipc = p; t.ipc4 = p4; t.instr = ins; t.valid = v;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic rd,
                       input logic rdy, input logic [31:0] rp);
    rst = r; stall = s; flush = f; redirect = rd; ready = rdy; redirect_pc = rp;
  endtask

  initial begin
    // cols: stall flush redirect ready rpc | addr ifid_pc ifid_pc4 ifid_instr valid
    tbl[0]  = mk(0,0,0,1,0,         32'h04,  32'h00,  32'h04,  32'h1000, 1);
    tbl[1]  = mk(0,0,0,1,0,         32'h08,  32'h04,  32'h08,  32'h1004, 1);
    tbl[2]  = mk(0,0,0,1,0,         32'h0C,  32'h08,  32'h0C,  32'h1008, 1);
    tbl[3]  = mk(0,0,0,1,0,         32'h10,  32'h0C,  32'h10,  32'h100C, 1);
    tbl[4]  = mk(1,0,0,1,0,         32'h10,  32'h0C,  32'h10,  32'h100C, 1);
    tbl[5]  = mk(1,0,0,1,0,         32'h10,  32'h0C,  32'h10,  32'h100C, 1);
    tbl[6]  = mk(1,0,0,1,0,         32'h10,  32'h0C,  32'h10,  32'h100C, 1);
    tbl[7]  = mk(0,0,0,1,0,         32'h14,  32'h10,  32'h14,  32'h1010, 1);
    tbl[8]  = mk(0,0,0,1,0,         32'h18,  32'h14,  32'h18,  32'h1014, 1);
    tbl[9]  = mk(0,0,0,1,0,         32'h1C,  32'h18,  32'h1C,  32'h1018, 1);
    tbl[10] = mk(0,0,0,1,0,         32'h20,  32'h1C,  32'h20,  32'h101C, 1);
    tbl[11] = mk(0,0,0,0,0,         32'h20,  32'h00,  32'h00,  32'h0000, 0);
    tbl[12] = mk(0,0,0,0,0,         32'h20,  32'h00,  32'h00,  32'h0000, 0);
    tbl[13] = mk(0,0,0,1,0,         32'h24,  32'h20,  32'h24,  32'h1020, 1);
    tbl[14] = mk(0,1,0,1,0,         32'h28,  32'h00,  32'h00,  32'h0000, 0);
    tbl[15] = mk(0,0,0,1,0,         32'h2C,  32'h28,  32'h2C,  32'h1028, 1);
    tbl[16] = mk(1,1,0,1,0,         32'h2C,  32'h00,  32'h00,  32'h0000, 0);
    tbl[17] = mk(0,0,0,1,0,         32'h30,  32'h2C,  32'h30,  32'h102C, 1);
    tbl[18] = mk(1,0,1,1,32'h103,   32'h100, 32'h00,  32'h00,  32'h0000, 0);
    tbl[19] = mk(0,0,0,1,0,         32'h104, 32'h100, 32'h104, 32'h1100, 1);
    tbl[20] = mk(0,0,1,0,32'h202,   32'h200, 32'h00,  32'h00,  32'h0000, 0);
    tbl[21] = mk(0,0,0,1,0,         32'h204, 32'h200, 32'h204, 32'h1200, 1);

    // Wrap-around on the instance reset to 0xFFFF_FFF8.
    drive(1, 0, 0, 0, 1, 0);
    step();
    chk("wrap_rst_addr", addr2, 32'hFFFF_FFF8);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", ipc, 32'h0);
    chk("rst_pc4", ipc4, 32'h0);
    drive(0, 0, 0, 0, 1, 0);
    step();
    chk("wrap_addr1", addr2, 32'hFFFF_FFFC);
    chk("wrap_ifid_pc1", ipc2, 32'hFFFF_FFF8);
    chk("wrap_ifid_pc4_1", ipc42, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr2", addr2, 32'h0000_0000);
    chk("wrap_ifid_pc2", ipc2, 32'hFFFF_FFFC);
    chk("wrap_ifid_pc4_2", ipc42, 32'h0000_0000);
    chk("wrap_ifid_instr2", instr2, 32'h0000_0FFC);
    chk("wrap_valid2", {31'b0, valid2}, 32'h1);

    // Fresh reset, then the vector table.
    drive(1, 0, 0, 0, 1, 0);
    step();
    chk("rst2_addr", addr, 32'h0);
    for (int i = 0; i < 22; i++) begin
      drive(0, tbl[i].stall, tbl[i].flush, tbl[i].redirect, tbl[i].ready, tbl[i].rpc);
      step();
      chk($sformatf("v%0d_addr", i), addr, tbl[i].addr);
      chk($sformatf("v%0d_ifid_pc", i), ipc, tbl[i].ipc);
      chk($sformatf("v%0d_ifid_pc4", i), ipc4, tbl[i].ipc4);
      chk($sformatf("v%0d_ifid_instr", i), instr, tbl[i].instr);
      chk($sformatf("v%0d_ifid_valid", i), {31'b0, valid}, {31'b0, tbl[i].valid});
    end

    // Reset wins over a simultaneous stall and redirect.
    drive(1, 1, 0, 1, 1, 32'h300);
    step();
    chk("rst_mid_addr", addr, 32'h0);
    chk("rst_mid_pc", ipc, 32'h0);
    chk("rst_mid_pc4", ipc4, 32'h0);
    chk("rst_mid_instr", instr, 32'h0);
    chk("rst_mid_valid", {31'b0, valid}, 32'h0);
    chk("rst_mid_wrap_addr", addr2, 32'hFFFF_FFF8);
    drive(0, 0, 0, 0, 1, 0);
    step();
    chk("post_rst_addr", addr, 32'h4);
    chk("post_rst_instr", instr, 32'h1000);
    chk("post_rst_valid", {31'b0, valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
